// File: rtl/mtm_alu_pkg.sv
// Shared types and constants for the MTM ALU serial link.
package mtm_alu_pkg;

  localparam int unsigned PACKET_W  = 10;
  localparam int unsigned DATA_BITS = 10;
  localparam int unsigned BIT_CNT_W = 4;
  localparam int unsigned GAP_CNT_W = 3;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  typedef logic [PACKET_W-1:0] packet_t;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    GAP
  } ser_state_e;

endpackage

// File: rtl/mtm_alu_ser_fifo.sv
// Packet FIFO feeding the serializer; DEPTH must be a power of two.
module mtm_alu_ser_fifo
  import mtm_alu_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    push,
  input  packet_t push_data,
  input  logic    pop,
  output packet_t pop_data,
  output logic    full,
  output logic    empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  packet_t       mem_q [DEPTH];
  logic          do_push;
  logic          do_pop;

  assign full     = (count_q == CW'(DEPTH));
  assign empty    = (count_q == '0);
  assign do_push  = push & ~full;
  assign do_pop   = pop & ~empty;
  assign pop_data = mem_q[rd_ptr_q];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q + CW'(do_push) - CW'(do_pop);
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/mtm_alu_serializer.sv
// Serializes 10-bit packets into start/data/stop frames on an idle-high line.
// Define MTM_ALU_SER_FIFO_EN for a FIFO_DEPTH input FIFO; otherwise one holding register.
module mtm_alu_serializer
  import mtm_alu_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned GAP_CYCLES = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [PACKET_W-1:0] packet,
  input  logic                packet_valid,
  output logic                packet_ready,
  output logic                sout,
  output logic                busy
);

  if ((FIFO_DEPTH < 2) || (FIFO_DEPTH > 16) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("FIFO_DEPTH must be a power of two in 2..16");
  end
  if ((GAP_CYCLES < 1) || (GAP_CYCLES > 7)) begin : g_bad_gap
    $error("GAP_CYCLES must be in 1..7");
  end

  ser_state_e           state_q, state_d;
  packet_t              shift_q, shift_d;
  logic [BIT_CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [GAP_CNT_W-1:0] gap_cnt_q, gap_cnt_d;
  logic                 sout_q, sout_d;
  logic                 busy_q, busy_d;
  logic                 ready_en_q, ready_en_d;

  logic    buf_empty;
  logic    buf_room;
  packet_t buf_head;
  logic    buf_pop;
  logic    buf_push;
  logic    accept;
  logic    gap_last;
  logic    launch;
  logic    bypass;

  // A new frame may start from IDLE or on the last gap cycle; an empty buffer
  // lets the incoming word go straight into the shift register.
  assign gap_last     = (gap_cnt_q == GAP_CNT_W'(GAP_CYCLES - 1));
  assign launch       = (state_q == IDLE) | ((state_q == GAP) & gap_last);
  assign buf_pop      = launch & ~buf_empty;
  assign packet_ready = ready_en_q & buf_room;
  assign accept       = packet_valid & packet_ready;
  assign bypass       = launch & buf_empty & accept;
  assign buf_push     = accept & ~bypass;

`ifdef MTM_ALU_SER_FIFO_EN
  logic fifo_full;

  mtm_alu_ser_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (buf_push),
    .push_data(packet),
    .pop      (buf_pop),
    .pop_data (buf_head),
    .full     (fifo_full),
    .empty    (buf_empty)
  );

  assign buf_room = ~fifo_full;
`else
  packet_t hold_q, hold_d;
  logic    hold_valid_q, hold_valid_d;

  assign buf_empty = ~hold_valid_q;
  assign buf_head  = hold_q;
  assign buf_room  = ~hold_valid_q | buf_pop;

  always_comb begin
    hold_d       = hold_q;
    hold_valid_d = hold_valid_q;
    if (buf_pop) hold_valid_d = 1'b0;
    if (buf_push) begin
      hold_d       = packet;
      hold_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_q       <= '0;
      hold_valid_q <= 1'b0;
    end else begin
      hold_q       <= hold_d;
      hold_valid_q <= hold_valid_d;
    end
  end
`endif

  // Frame sequencer; sout and busy are derived from the next state so they are registered.
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bit_cnt_d  = bit_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    ready_en_d = 1'b1;
    case (state_q)
      IDLE: begin
        if (buf_pop || bypass) begin
          state_d = START;
          shift_d = buf_pop ? buf_head : packet;
        end
      end
      START: begin
        state_d   = DATA;
        bit_cnt_d = '0;
      end
      DATA: begin
        if (bit_cnt_q == BIT_CNT_W'(DATA_BITS - 1)) begin
          state_d   = STOP;
          bit_cnt_d = '0;
        end else begin
          bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
          shift_d   = {shift_q[PACKET_W-2:0], 1'b0};
        end
      end
      STOP: begin
        state_d   = GAP;
        gap_cnt_d = '0;
      end
      GAP: begin
        if (gap_last) begin
          gap_cnt_d = '0;
          if (buf_pop || bypass) begin
            state_d = START;
            shift_d = buf_pop ? buf_head : packet;
          end else begin
            state_d = IDLE;
          end
        end else begin
          gap_cnt_d = gap_cnt_q + GAP_CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    case (state_d)
      START:   sout_d = START_BIT;
      DATA:    sout_d = shift_d[PACKET_W-1];
      default: sout_d = STOP_BIT;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      gap_cnt_q  <= '0;
      sout_q     <= STOP_BIT;
      busy_q     <= 1'b0;
      ready_en_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      bit_cnt_q  <= bit_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
      sout_q     <= sout_d;
      busy_q     <= busy_d;
      ready_en_q <= ready_en_d;
    end
  end

  assign sout = sout_q;
  assign busy = busy_q;

endmodule

// File: doc/mtm_alu_serializer.md
MTM_ALU_SERIALIZER -- requirements
Module: mtm_alu_serializer

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, input buffer depth in packets (power of two, 2..16; used only with MTM_ALU_SER_FIFO_EN).
REQ-002 SHALL have parameter GAP_CYCLES, default 1, minimum idle-high cycles between a stop bit and the next start bit (1..7).
REQ-003 SHALL have port clk  input  1  single system clock, all logic on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port packet  input  10  packet to transmit, bit 9 sent first.
REQ-006 SHALL have port packet_valid  input  1  packet holds a valid word.
REQ-007 SHALL have port packet_ready  output  1  block can accept a word this cycle.
REQ-008 SHALL have port sout  output  1  registered serial line, idle high.
REQ-009 SHALL have port busy  output  1  high while a frame, gap or buffered word is pending.

Function
REQ-010 SHALL accept a word only on a cycle with packet_valid=1 and packet_ready=1; packet is ignored otherwise.
REQ-011 SHALL send each frame as one start bit (0), ten data bits MSB first (packet[9]..packet[0]), one stop bit (1), one bit per clk cycle: 12 cycles per frame.
REQ-012 SHALL use states IDLE, START, DATA, STOP, GAP; IDLE->START when a word is available; START->DATA after 1 cycle; DATA->STOP after 10 cycles (4-bit bit counter 0..9); STOP->GAP after 1 cycle; GAP->IDLE after GAP_CYCLES cycles.
REQ-013 SHALL drive sout=1 in IDLE, STOP and GAP, sout=0 in START, sout=shift register MSB in DATA.
REQ-014 SHALL drive sout low (start bit) on the cycle after the accept cycle when in IDLE with an empty buffer (latency 1 cycle from handshake to start bit).
REQ-015 SHALL, with a word buffered at GAP end, go GAP->START directly, never spending a cycle in IDLE.
REQ-016 SHALL capture the word into a 10-bit shift register on entry to START; later changes of packet SHALL NOT affect the frame in flight.
REQ-017 SHALL keep busy=0 only when state is IDLE and buffer is empty.
REQ-018 SHALL allow a simultaneous accept and buffer pop in the same cycle with no loss or duplication.

Reset
REQ-019 SHALL, when rst=1 on a rising edge, set state IDLE, sout=1, busy=0, bit and gap counters 0, buffer empty, packet_ready=0 on the next cycle.
REQ-020 SHALL, on reset mid-frame, abort the frame immediately (sout=1 next cycle) and discard all buffered words.
REQ-021 SHALL raise packet_ready no earlier than the first cycle after rst deasserts.

Configuration
REQ-022 SHALL, with macro MTM_ALU_SER_FIFO_EN defined, buffer inputs in a FIFO_DEPTH-entry FIFO; packet_ready=1 iff FIFO not full; a push while full SHALL NOT occur; pointers wrap modulo FIFO_DEPTH.
REQ-023 SHALL, with MTM_ALU_SER_FIFO_EN undefined, use a single 10-bit holding register; packet_ready=1 iff the holding register is empty or is being moved into the shift register that cycle.

Structure
REQ-024 SHALL take state encoding (IDLE, START, DATA, STOP, GAP), frame constants (DATA_BITS=10, START_BIT=0, STOP_BIT=1) and the packet width from shared package mtm_alu_pkg.
REQ-025 SHALL place the FIFO in sub-module mtm_alu_ser_fifo (push/pop/full/empty, synchronous rst), instantiated only when MTM_ALU_SER_FIFO_EN is defined.

Verification
REQ-026 SHALL verify single frame: after reset, packet=10'h2A5 valid one cycle -> sout next cycles 0,1,0,1,0,1,0,0,1,0,1,1 then high; busy low after GAP_CYCLES.
REQ-027 SHALL verify back-to-back: 10'h3FF then 10'h000 presented continuously -> frames separated by exactly GAP_CYCLES=1 high cycles, no IDLE cycle.
REQ-028 SHALL verify backpressure: with FIFO enabled, 6 words pushed while sending -> packet_ready falls after 4 buffered (plus 1 in flight), all 6 frames emitted in order.
REQ-029 SHALL verify mid-frame reset: rst=1 during DATA bit 5 of 10'h155 -> sout=1 next cycle, busy=0, buffer empty, no remaining bits emitted.
REQ-030 SHALL verify loopback: sout fed to mtm_Alu_deserializer (its rst driven as !rst) -> 100 random packets received unchanged with one data_valid each.
